// File: rtl/window_scan_scheduler.sv
// window_scan_scheduler: steps a detection window over an integral-image frame,
// presents the six classifier corner addresses, handshakes the classifier and streams hits.
module window_scan_scheduler #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int WIN_W     = 24,
    parameter int WIN_H     = 24,
    parameter int STEP      = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic [14:0] address_0,
    output logic [14:0] address_1,
    output logic [14:0] address_2,
    output logic [14:0] address_3,
    output logic [14:0] address_4,
    output logic [14:0] address_5,
    output logic        detect_en,
    input  logic        detect_done,
    input  logic        detected_flag,
    output logic        hit_valid,
    input  logic        hit_ready,
    output logic [7:0]  hit_x,
    output logic [6:0]  hit_y,
    output logic [15:0] hit_count,
    output logic        timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FIRE, S_WAIT, S_RESULT, S_ADVANCE, S_DONE} state_t;

    state_t        r_state;
    logic [7:0]    r_x0;
    logic [6:0]    r_y0;
    logic [TW-1:0] r_tcnt;

    logic [14:0] w_l, w_m, w_r, w_t, w_b;
    logic        w_x_more, w_y_more;

    assign w_l      = 15'(r_x0);
    assign w_m      = w_l + 15'(WIN_W / 2 - 1);
    assign w_r      = w_l + 15'(WIN_W - 1);
    assign w_t      = 15'(r_y0) * 15'(II_WIDTH);
    assign w_b      = (15'(r_y0) + 15'(WIN_H - 1)) * 15'(II_WIDTH);
    assign w_x_more = int'(r_x0) + STEP + WIN_W <= II_WIDTH;
    assign w_y_more = int'(r_y0) + STEP + WIN_H <= II_HEIGHT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_tcnt      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            address_0   <= '0;
            address_1   <= '0;
            address_2   <= '0;
            address_3   <= '0;
            address_4   <= '0;
            address_5   <= '0;
            detect_en   <= 1'b0;
            hit_valid   <= 1'b0;
            hit_x       <= '0;
            hit_y       <= '0;
            hit_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    busy        <= 1'b1;
                    hit_count   <= '0;
                    timeout_err <= 1'b0;
                    r_x0        <= '0;
                    r_y0        <= '0;
                    r_state     <= S_SETUP;
                end
                S_SETUP: begin
                    address_3 <= w_t + w_l;
                    address_1 <= w_t + w_m;
                    address_5 <= w_t + w_r;
                    address_2 <= w_b + w_l;
                    address_0 <= w_b + w_m;
                    address_4 <= w_b + w_r;
                    r_state   <= S_FIRE;
                end
                S_FIRE: begin
                    detect_en <= 1'b1;
                    r_tcnt    <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: if (detect_done) begin
                    detect_en <= 1'b0;
                    hit_valid <= detected_flag;
                    if (detected_flag) begin
                        hit_x <= r_x0;
                        hit_y <= r_y0;
                    end
                    r_state <= S_RESULT;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    // abandoned window counts as a miss
                    detect_en   <= 1'b0;
                    timeout_err <= 1'b1;
                    r_state     <= S_ADVANCE;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                S_RESULT: if (!hit_valid) begin
                    r_state <= S_ADVANCE;
                end else if (hit_ready) begin
                    hit_valid <= 1'b0;
                    hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
                    r_state   <= S_ADVANCE;
                end
                S_ADVANCE: if (w_x_more) begin
                    r_x0    <= r_x0 + 8'(STEP);
                    r_state <= S_SETUP;
                end else begin
                    r_x0 <= '0;
                    if (w_y_more) begin
                        r_y0    <= r_y0 + 7'(STEP);
                        r_state <= S_SETUP;
                    end else begin
                        frame_done <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_scan_scheduler.sv
// tb_window_scan_scheduler: drives a small-geometry and a default-geometry scheduler with a
// behavioural classifier and checks addresses, hits and frame control against raster-order origin lists.
module tb_window_scan_scheduler;
    localparam int SW = 16, SH = 8, SWW = 8, SWH = 4, STEP = 4, TMO = 64;
    localparam int BW = 160, BH = 120, BWW = 24, BWH = 24;

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    logic        s_start, s_busy, s_fd, s_en, s_done, s_flag, s_hv, s_hr, s_te;
    logic [14:0] s_addr [6];
    logic [7:0]  s_hx;
    logic [6:0]  s_hy;
    logic [15:0] s_hc;
    logic        b_start, b_busy, b_fd, b_en, b_done, b_flag, b_hv, b_hr, b_te;
    logic [14:0] b_addr [6];
    logic [7:0]  b_hx;
    logic [6:0]  b_hy;
    logic [15:0] b_hc;

    window_scan_scheduler #(.II_WIDTH(SW), .II_HEIGHT(SH), .WIN_W(SWW), .WIN_H(SWH), .STEP(STEP), .TIMEOUT(TMO)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .frame_done(s_fd),
        .address_0(s_addr[0]), .address_1(s_addr[1]), .address_2(s_addr[2]),
        .address_3(s_addr[3]), .address_4(s_addr[4]), .address_5(s_addr[5]),
        .detect_en(s_en), .detect_done(s_done), .detected_flag(s_flag),
        .hit_valid(s_hv), .hit_ready(s_hr), .hit_x(s_hx), .hit_y(s_hy),
        .hit_count(s_hc), .timeout_err(s_te));

    window_scan_scheduler dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .frame_done(b_fd),
        .address_0(b_addr[0]), .address_1(b_addr[1]), .address_2(b_addr[2]),
        .address_3(b_addr[3]), .address_4(b_addr[4]), .address_5(b_addr[5]),
        .detect_en(b_en), .detect_done(b_done), .detected_flag(b_flag),
        .hit_valid(b_hv), .hit_ready(b_hr), .hit_x(b_hx), .hit_y(b_hy),
        .hit_count(b_hc), .timeout_err(b_te));

    int vectors = 0, miscompares = 0;
    int s_ox[$], s_oy[$], b_ox[$], b_oy[$];
    int s_exp_hc;
    bit s_exp_te;

    // Corner k of the window at (x,y): k=3/1/5 top L/M/R, k=2/0/4 bottom L/M/R.
    function automatic logic [14:0] corner(int k, int x, int y, int w, int ww, int wh);
        int col, row;
        col = (k == 2 || k == 3) ? x : (k == 0 || k == 1) ? x + ww / 2 - 1 : x + ww - 1;
        row = (k == 1 || k == 3 || k == 5) ? y : y + wh - 1;
        return 15'(row * w + col);
    endfunction

    task automatic start_s();
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        s_exp_hc = 0;
        s_exp_te = 1'b0;
        vectors++;
        if ({s_busy, s_hc, s_te} !== {1'b1, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL start_s busy/hc/te got %b/%0d/%b want 1/0/0", s_busy, s_hc, s_te);
        end
    endtask

    // Acts as the classifier for one small-geometry frame and checks every window.
    task automatic drive_frame_s(input int nodone_win, input bit rand_hits, input int start_win,
                                 input int abort_win, input int fixed_lat);
        int n, lat, d;
        bit f;
        logic [14:0] e;
        for (int i = 0; i < s_ox.size(); i++) begin
            n = 0;
            while (!s_en && n < 200) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (!s_en || (i > 0 && n < 2)) begin
                miscompares++;
                $display("FAIL s_launch win=%0d en=%b low_cycles=%0d want en=1 low>=2", i, s_en, n);
                if (!s_en) return;
            end
            for (int k = 0; k < 6; k++) begin
                e = corner(k, s_ox[i], s_oy[i], SW, SWW, SWH);
                vectors++;
                if (s_addr[k] !== e) begin
                    miscompares++;
                    $display("FAIL s_addr%0d win=(%0d,%0d) got %0d want %0d", k, s_ox[i], s_oy[i], s_addr[k], e);
                end
            end
            vectors++;
            if ({s_fd, s_busy} !== 2'b01) begin
                miscompares++;
                $display("FAIL s_midscan fd/busy got %b/%b want 0/1", s_fd, s_busy);
            end
            if (i == abort_win) begin
                #2 rst = 1'b0;
                #1;
                vectors++;
                if ({s_en, s_busy, s_hv, s_hc} !== 19'd0) begin
                    miscompares++;
                    $display("FAIL s_abort en/busy/hv/hc got %b/%b/%b/%0d want 0/0/0/0", s_en, s_busy, s_hv, s_hc);
                end
                s_hr = 1'b0;
                @(negedge clk) rst = 1'b1;
                return;
            end
            if (i == start_win) s_start = 1'b1;
            if (i == nodone_win) begin
                n = 0;
                while (s_en && n < 200) begin
                    @(negedge clk);
                    s_start = 1'b0;
                    n++;
                end
                s_exp_te = 1'b1;
                vectors++;
                if (n != TMO || {s_te, s_hv} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL s_timeout wait=%0d te=%b hv=%b want %0d/1/0", n, s_te, s_hv, TMO);
                end
                continue;
            end
            lat = fixed_lat > 0 ? fixed_lat : $urandom_range(1, 12);
            f = rand_hits && $urandom_range(0, 2) == 0;
            if (rand_hits) s_hr = f ? 1'b0 : 1'($urandom_range(0, 1));
            for (int k = 0; k < lat - 1; k++) begin
                @(negedge clk);
                s_start = 1'b0;
            end
            s_done = 1'b1;
            s_flag = f;
            if (f) s_hr = 1'b0;
            @(negedge clk);
            s_start = 1'b0;
            s_done = 1'b0;
            s_flag = 1'b0;
            if (f) begin
                d = $urandom_range(0, 5);
                for (int c = 0; c <= d; c++) begin
                    vectors++;
                    if ({s_hv, s_en, s_hx, s_hy} !== {1'b1, 1'b0, 8'(s_ox[i]), 7'(s_oy[i])}) begin
                        miscompares++;
                        $display("FAIL s_hit_hold hv/en/x/y got %b/%b/%0d/%0d want 1/0/%0d/%0d",
                                 s_hv, s_en, s_hx, s_hy, s_ox[i], s_oy[i]);
                    end
                    if (c < d) @(negedge clk);
                end
                s_hr = 1'b1;
                @(negedge clk) s_hr = 1'b0;
                s_exp_hc = s_exp_hc == 65535 ? s_exp_hc : s_exp_hc + 1;
            end
            vectors++;
            if ({s_hv, s_en, s_hc} !== {2'b00, 16'(s_exp_hc)}) begin
                miscompares++;
                $display("FAIL s_result hv/en/hc got %b/%b/%0d want 0/0/%0d", s_hv, s_en, s_hc, s_exp_hc);
            end
        end
        n = 0;
        while (!s_fd && n < 20) begin
            @(negedge clk);
            n++;
        end
        s_hr = 1'b0;
        vectors++;
        if ({s_fd, s_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL s_frame_done fd/busy got %b/%b want 1/1", s_fd, s_busy);
        end
        @(negedge clk);
        vectors++;
        if ({s_fd, s_busy, s_hc, s_te} !== {2'b00, 16'(s_exp_hc), s_exp_te}) begin
            miscompares++;
            $display("FAIL s_frame_end fd/busy/hc/te got %b/%b/%0d/%b want 0/0/%0d/%b",
                     s_fd, s_busy, s_hc, s_te, s_exp_hc, s_exp_te);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({s_en, s_fd, s_busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL s_after_frame en/fd/busy got %b/%b/%b want 0/0/0", s_en, s_fd, s_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_busy, s_fd, s_en, s_hv, s_te, b_busy, b_fd, b_en, b_hv, b_te} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0", {s_busy, s_fd, s_en, s_hv, s_te, b_busy, b_fd, b_en, b_hv, b_te});
        end
        vectors++;
        if ({s_addr[0], s_addr[1], s_addr[2], s_addr[3], s_addr[4], s_addr[5]} !== 90'd0) begin
            miscompares++;
            $display("FAIL reset_s_addr got nonzero want 0");
        end
        vectors++;
        if ({b_addr[0], b_addr[1], b_addr[2], b_addr[3], b_addr[4], b_addr[5]} !== 90'd0) begin
            miscompares++;
            $display("FAIL reset_b_addr got nonzero want 0");
        end
        vectors++;
        if ({s_hx, s_hy, s_hc, b_hx, b_hy, b_hc} !== 62'd0) begin
            miscompares++;
            $display("FAIL reset_hits got %0d/%0d/%0d %0d/%0d/%0d want 0", s_hx, s_hy, s_hc, b_hx, b_hy, b_hc);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_scan();
        start_s();
        drive_frame_s(-1, 1'b0, -1, -1, 10);
    endtask

    task automatic test_ignored_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk) {s_done, s_flag, s_hr} = 3'b111;
            @(negedge clk) {s_done, s_flag} = 2'b00;
            vectors++;
            if ({s_busy, s_hv, s_en, s_hc} !== {3'b000, 16'(s_exp_hc)}) begin
                miscompares++;
                $display("FAIL idle_done busy/hv/en/hc got %b/%b/%b/%0d want 0/0/0/%0d", s_busy, s_hv, s_en, s_hc, s_exp_hc);
            end
        end
        start_s();
        drive_frame_s(-1, 1'b0, 2, -1, 5);
        s_hr = 1'b0;
    endtask

    task automatic test_timeout();
        start_s();
        drive_frame_s(3, 1'b1, -1, -1, 0);
        start_s();
        drive_frame_s(-1, 1'b1, -1, -1, 0);
    endtask

    task automatic test_rst_mid_scan();
        start_s();
        drive_frame_s(-1, 1'b1, -1, 5, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({s_busy, s_en, s_fd} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_abort busy/en/fd got %b/%b/%b want 0/0/0", s_busy, s_en, s_fd);
        end
        start_s();
        drive_frame_s(-1, 1'b1, -1, -1, 0);
    endtask

    task automatic test_random_frames();
        for (int fr = 0; fr < 6; fr++) begin
            start_s();
            drive_frame_s($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 5)) : -1, 1'b1,
                          $urandom_range(0, 1) == 0 ? int'($urandom_range(0, 5)) : -1, -1, 0);
        end
    endtask

    task automatic test_hit_backpressure();
        int n, lat;
        bit f;
        logic [14:0] e;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        for (int i = 0; i < b_ox.size(); i++) begin
            n = 0;
            while (!b_en && n < 200) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (!b_en) begin
                miscompares++;
                $display("FAIL b_launch win=%0d got en=0 want 1", i);
                return;
            end
            for (int k = 0; k < 6; k++) begin
                e = corner(k, b_ox[i], b_oy[i], BW, BWW, BWH);
                vectors++;
                if (b_addr[k] !== e) begin
                    miscompares++;
                    $display("FAIL b_addr%0d win=(%0d,%0d) got %0d want %0d", k, b_ox[i], b_oy[i], b_addr[k], e);
                end
            end
            f = b_ox[i] == 40 && b_oy[i] == 20;
            lat = $urandom_range(1, 4);
            for (int k = 0; k < lat - 1; k++) @(negedge clk);
            {b_done, b_flag} = {1'b1, f};
            @(negedge clk) {b_done, b_flag} = 2'b00;
            if (f) begin
                for (int c = 0; c < 20; c++) begin
                    vectors++;
                    if ({b_hv, b_en, b_hx, b_hy} !== {1'b1, 1'b0, 8'd40, 7'd20}) begin
                        miscompares++;
                        $display("FAIL b_hit_hold cyc=%0d hv/en/x/y got %b/%b/%0d/%0d want 1/0/40/20", c, b_hv, b_en, b_hx, b_hy);
                    end
                    @(negedge clk);
                end
                b_hr = 1'b1;
                @(negedge clk) b_hr = 1'b0;
            end
            vectors++;
            if ({b_hv, b_hc} !== {1'b0, 16'(int'(b_oy[i] > 20 || (b_oy[i] == 20 && b_ox[i] >= 40)))}) begin
                miscompares++;
                $display("FAIL b_result win=(%0d,%0d) hv/hc got %b/%0d", b_ox[i], b_oy[i], b_hv, b_hc);
            end
        end
        n = 0;
        while (!b_fd && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!b_fd) begin
            miscompares++;
            $display("FAIL b_frame_done got 0 want 1");
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({b_busy, b_en, b_hc, b_te} !== {2'b00, 16'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL b_frame_end busy/en/hc/te got %b/%b/%0d/%b want 0/0/1/0", b_busy, b_en, b_hc, b_te);
        end
    endtask

    initial begin
        {s_start, s_done, s_flag, s_hr, b_start, b_done, b_flag, b_hr} = '0;
        for (int y = 0; y + SWH <= SH; y += STEP)
            for (int x = 0; x + SWW <= SW; x += STEP) begin
                s_ox.push_back(x);
                s_oy.push_back(y);
            end
        for (int y = 0; y + BWH <= BH; y += STEP)
            for (int x = 0; x + BWW <= BW; x += STEP) begin
                b_ox.push_back(x);
                b_oy.push_back(y);
            end
        test_reset();
        test_scan();
        test_ignored_inputs();
        test_timeout();
        test_rst_mid_scan();
        test_random_frames();
        test_hit_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/window_scan_scheduler.md
Name: window_scan_scheduler

Overview:
Sequences the 2x1 (two-horizontal) feature classifier across a full integral-image frame. It steps a detection window over the 160x120 buffer, computes the six corner read addresses per window, and handshakes with the classifier (detect_en / detect_done). Positive results are emitted as window coordinates over a valid/ready stream to the downstream overlay/reporting logic. It sits between the frame-ready signal of the integral-image builder and the classifier.

Parameters:
II_WIDTH, 160, integral image width in pixels
II_HEIGHT, 120, integral image height in pixels
WIN_W, 24, window width; must be even and >= 2
WIN_H, 24, window height; must be >= 2
STEP, 4, window stride in x and y
TIMEOUT, 64, max cycles to wait for detect_done before abandoning a window

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: scan current frame; ignored while busy=1
busy  out  1  high from the cycle after accepted start until frame_done
frame_done  out  1  one-cycle pulse after last window is retired
address_0..address_5  out  15 each  classifier corner addresses (see Behaviour)
detect_en  out  1  to classifier; rising edge launches one evaluation
detect_done  in  1  from classifier; one-cycle completion pulse
detected_flag  in  1  from classifier; valid in the detect_done cycle
hit_valid  out  1  hit coordinate available
hit_ready  in  1  downstream accepts hit when hit_valid&&hit_ready
hit_x  out  8  window origin column of hit
hit_y  out  7  window origin row of hit
hit_count  out  16  hits in current/last frame; cleared on accepted start
timeout_err  out  1  sticky; set on any timeout; cleared on accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; x0=y0=0; counters 0.
- Window origins: x0 = 0, STEP, ... while x0+WIN_W <= II_WIDTH; y0 likewise with WIN_H/II_HEIGHT. Raster order, x fastest.
- Corners: L=x0, M=x0+WIN_W/2-1, R=x0+WIN_W-1, T=y0, B=y0+WIN_H-1; addr(col,row)=row*II_WIDTH+col, 15-bit unsigned.
- address_3=(L,T), address_1=(M,T), address_5=(R,T), address_2=(L,B), address_0=(M,B), address_4=(R,B).
- Addresses registered; stable from SETUP through WAIT of the same window.
- FSM:
  - IDLE: on start -> SETUP; clear hit_count, timeout_err, x0, y0; busy=1.
  - SETUP (1 cycle): register six addresses -> FIRE.
  - FIRE (1 cycle): detect_en<=1 -> WAIT; clear timeout counter.
  - WAIT: detect_en held 1. On detect_done: capture detected_flag, detect_en<=0, -> RESULT. Else if counter reaches TIMEOUT-1: timeout_err<=1, detect_en<=0, flag treated as 0, -> ADVANCE.
  - RESULT: flag=0 -> ADVANCE. flag=1 -> hit_valid=1, hit_x=x0, hit_y=y0, hold stable until hit_ready; on handshake hit_valid<=0, hit_count+=1 (saturates at 0xFFFF) -> ADVANCE. hit_ready while hit_valid=0 ignored.
  - ADVANCE: step x0; wrap x0 to 0 and step y0 at row end; past last row -> DONE, else -> SETUP.
  - DONE (1 cycle): frame_done=1, busy<=0 -> IDLE.
- detect_en low for >=2 cycles between windows (RESULT/ADVANCE/SETUP) guaranteeing a clean rising edge.
- detect_done outside WAIT ignored. start while busy ignored.
- Per-window latency without stall: SETUP+FIRE+classifier latency+RESULT+ADVANCE.
- rst mid-scan: immediate abort to IDLE; no frame_done; detect_en drops asynchronously.

Test Plan:
- Params II_WIDTH=16, II_HEIGHT=8, WIN_W=8, WIN_H=4, STEP=4; classifier model: done 10 cycles after detect_en rise, flag=0 -> exactly 6 detect_en rises, origins (0,0),(4,0),(8,0),(0,4),(4,4),(8,4); one frame_done; hit_count=0.
- Same, window (0,0): address_3=0, address_1=3, address_5=7, address_2=48, address_0=51, address_4=55; window (8,4): 72,75,79,120,123,127.
- Defaults, flag=1 only at origin (40,20), hit_ready held 0 for 20 cycles -> hit_valid with hit_x=40, hit_y=20 stable 20 cycles; no further detect_en rise until handshake; end hit_count=1; total 35*25=875 windows.
- Model never returns done for window 3 -> after 64 WAIT cycles timeout_err=1, scan continues, frame_done still pulses; next start clears timeout_err.
- start pulsed mid-scan and spurious detect_done in IDLE -> no effect; hit_count unchanged.
- rst low during WAIT of window 5 -> detect_en, busy, hit_valid 0 immediately; after release, start rescans from (0,0).
